// File: rtl/option_dispatch.sv
// rtl/option_dispatch.sv - round-robin option packet dispatch to pricing engines and result merge
module option_dispatch #(
    parameter int NUM_ENGINES = 4,
    parameter int PKT_W       = 200,
    parameter int ID_W        = 32,
    parameter int PRICE_W     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PKT_W-1:0]                 in_packet,
    output logic [NUM_ENGINES-1:0]           eng_start,
    output logic [PKT_W-1:0]                 eng_packet,
    input  logic [NUM_ENGINES-1:0]           eng_done,
    input  logic [NUM_ENGINES*PRICE_W-1:0]   eng_price,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ID_W-1:0]                  res_option_id,
    output logic [PRICE_W-1:0]               res_price,
    output logic [$clog2(NUM_ENGINES)-1:0]   res_engine,
    output logic [$clog2(NUM_ENGINES):0]     busy_count,
    output logic                             err_spurious
);

    localparam int IDX_W = $clog2(NUM_ENGINES);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [NUM_ENGINES-1:0] ONE_HOT0 = {{(NUM_ENGINES-1){1'b0}}, 1'b1};

    logic [1:0]         slot_state     [NUM_ENGINES];
    logic [1:0]         slot_state_nxt [NUM_ENGINES];
    logic [ID_W-1:0]    slot_id        [NUM_ENGINES];
    logic [PRICE_W-1:0] slot_price     [NUM_ENGINES];

    logic [IDX_W-1:0]       disp_ptr;
    logic [IDX_W-1:0]       res_ptr;
    logic [NUM_ENGINES-1:0] idle_vec;
    logic [NUM_ENGINES-1:0] run_vec;
    logic [NUM_ENGINES-1:0] hold_vec;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       src_idx;
    logic                   dispatch;
    logic                   out_load;
    logic                   spurious;

    // Increment a slot index, wrapping at NUM_ENGINES (which need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        if (v == IDX_W'(NUM_ENGINES - 1)) begin
            r = '0;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // First set bit of req at or after ptr, wrapping; lowest set bit overall when none at/after ptr.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                                 input logic [IDX_W-1:0]       ptr);
        logic [IDX_W-1:0] hi_idx;
        logic [IDX_W-1:0] lo_idx;
        logic             hi_hit;
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (i >= int'(ptr)) begin
                    hi_idx = IDX_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        return hi_hit ? hi_idx : lo_idx;
    endfunction

    // Slot status vectors, readiness and occupancy, all from registered slot state.
    always_comb begin
        idle_vec   = '0;
        run_vec    = '0;
        hold_vec   = '0;
        busy_count = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            idle_vec[k] = (slot_state[k] == S_IDLE);
            run_vec[k]  = (slot_state[k] == S_RUN);
            hold_vec[k] = (slot_state[k] == S_HOLD);
            if (slot_state[k] != S_IDLE) begin
                busy_count = busy_count + CNT_W'(1);
            end
        end
        in_ready = |idle_vec;
    end

    // Arbitration: which idle slot takes a new packet, which held result goes out.
    always_comb begin
        grant_idx = rr_pick(idle_vec, disp_ptr);
        src_idx   = rr_pick(hold_vec, res_ptr);
        dispatch  = in_valid & in_ready;
        out_load  = (|hold_vec) & (~res_valid | res_ready);
        spurious  = |(eng_done & ~run_vec);
    end

    // Per-slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_state[k] <= S_IDLE;
            end
        end else begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_state[k] <= slot_state_nxt[k];
            end
        end
    end

    // Per-slot next state: dispatch starts work, done parks the result, output load frees it.
    always_comb begin
        for (int k = 0; k < NUM_ENGINES; k++) begin
            slot_state_nxt[k] = slot_state[k];
            case (slot_state[k])
                S_IDLE: begin
                    if (dispatch && (grant_idx == IDX_W'(k))) begin
                        slot_state_nxt[k] = S_RUN;
                    end
                end
                S_RUN: begin
                    if (eng_done[k]) begin
                        slot_state_nxt[k] = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_load && (src_idx == IDX_W'(k))) begin
                        slot_state_nxt[k] = S_IDLE;
                    end
                end
                default: begin
                    slot_state_nxt[k] = S_IDLE;
                end
            endcase
        end
    end

    // Dispatch side: start pulse, registered packet copy, option_id tag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_ptr   <= '0;
            eng_start  <= '0;
            eng_packet <= '0;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_id[k] <= '0;
            end
        end else begin
            eng_start <= '0;
            if (dispatch) begin
                disp_ptr           <= wrap_inc(grant_idx);
                eng_start          <= ONE_HOT0 << grant_idx;
                eng_packet         <= in_packet;
                slot_id[grant_idx] <= in_packet[PKT_W-1 -: ID_W];
            end
        end
    end

    // Capture engine prices on completion of running slots only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_price[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                if (run_vec[k] && eng_done[k]) begin
                    slot_price[k] <= eng_price[k*PRICE_W +: PRICE_W];
                end
            end
        end
    end

    // Output register: refill from a held slot whenever empty or being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ptr       <= '0;
            res_valid     <= 1'b0;
            res_option_id <= '0;
            res_price     <= '0;
            res_engine    <= '0;
        end else begin
            if (out_load) begin
                res_valid     <= 1'b1;
                res_option_id <= slot_id[src_idx];
                res_price     <= slot_price[src_idx];
                res_engine    <= src_idx;
                res_ptr       <= wrap_inc(src_idx);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Sticky flag for completions arriving on slots that were not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious <= 1'b0;
        end else if (spurious) begin
            err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_option_dispatch.sv
// tb/tb_option_dispatch.sv - self-checking bench for option_dispatch
module tb_option_dispatch;

    localparam int N     = 4;
    localparam int PKT_W = 200;
    localparam int ID_W  = 32;
    localparam int PW    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [PKT_W-1:0]  in_packet;
    logic [N-1:0]      eng_start;
    logic [PKT_W-1:0]  eng_packet;
    logic [N-1:0]      eng_done;
    logic [N*PW-1:0]   eng_price;
    logic              res_valid;
    logic              res_ready;
    logic [ID_W-1:0]   res_option_id;
    logic [PW-1:0]     res_price;
    logic [1:0]        res_engine;
    logic [2:0]        busy_count;
    logic              err_spurious;

    int n_checks = 0;
    int n_errs   = 0;

    option_dispatch #(.NUM_ENGINES(N), .PKT_W(PKT_W), .ID_W(ID_W), .PRICE_W(PW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .eng_start(eng_start), .eng_packet(eng_packet),
        .eng_done(eng_done), .eng_price(eng_price),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_option_id(res_option_id), .res_price(res_price), .res_engine(res_engine),
        .busy_count(busy_count), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [31:0] id);
        return {id, 8'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_price(input int k, input logic [PW-1:0] v);
        eng_price[k*PW +: PW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_packet = '0; eng_done = '0; eng_price = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Dispatch count packets back to back with ids base..base+count-1, checking start pulses.
    task automatic dispatch_seq(input string tag, input int base, input int count, input int first_eng);
        logic [PKT_W-1:0] p;
        for (int i = 0; i < count; i++) begin
            p = mk_pkt(32'(base + i));
            in_valid = 1'b1;
            in_packet = p;
            @(negedge clk);
            chk({tag, "_start"}, eng_start, 4'b0001 << ((first_eng + i) % N));
            chk({tag, "_pkt"}, eng_packet, p);
        end
        in_valid = 1'b0;
    endtask

    // Random-phase reference state.
    bit               m_busy [N];
    bit               run    [N];
    bit               pend   [N];
    int               timer  [N];
    int               done_cyc [N];
    logic [31:0]      exp_id [N];
    logic [31:0]      exp_price [N];
    int               m_dptr, m_rptr, exp_grant, cyc, e_exp, nbusy, c;
    bit               disp_pending, prev_valid, prev_ready, stuck, acc, exp_v, any_free;
    logic [PKT_W-1:0] exp_pkt;
    logic [31:0]      held_id, held_price, pr;
    int               held_eng;
    logic [31:0]      got_id [4];
    logic [31:0]      got_pr [4];
    int               got_eng [4];
    int               ngot;

    initial begin
        do_reset();
        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_packet", eng_packet, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_option_id, 0);
        chk("rst_busy", busy_count, 0);
        chk("rst_err", err_spurious, 0);

        // Four back-to-back packets land on engines 0..3
        dispatch_seq("t1", 1, 4, 0);
        chk("t1_full_ready", in_ready, 0);
        chk("t1_busy4", busy_count, 4);
        @(negedge clk);
        chk("t1_start_once", eng_start, 0);

        // Completions in order 2,0,3,1 come out in completion order
        res_ready = 1'b1;
        ngot = 0;
        for (int j = 0; j < 14; j++) begin
            eng_done = '0;
            if (j < 4) begin
                c = (j == 0) ? 2 : (j == 1) ? 0 : (j == 2) ? 3 : 1;
                eng_done[c] = 1'b1;
                set_price(c, 32'((c + 1) * 10));
            end
            @(negedge clk);
            if (res_valid && ngot < 4) begin
                got_id[ngot] = res_option_id; got_pr[ngot] = res_price; got_eng[ngot] = int'(res_engine);
                ngot++;
            end
        end
        chk("t2_count", ngot, 4);
        for (int j = 0; j < 4; j++) begin
            c = (j == 0) ? 2 : (j == 1) ? 0 : (j == 2) ? 3 : 1;
            chk("t2_eng", got_eng[j], c);
            chk("t2_id", got_id[j], c + 1);
            chk("t2_price", got_pr[j], (c + 1) * 10);
        end
        chk("t2_busy0", busy_count, 0);

        // All four done together, output stalled for five cycles
        do_reset();
        dispatch_seq("t3", 5, 4, 0);
        eng_done = 4'hF;
        for (int k = 0; k < N; k++) set_price(k, 32'(1000 + k));
        @(negedge clk);
        eng_done = '0;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk("t3_stall_valid", res_valid, 1);
            chk("t3_stall_eng", res_engine, 0);
            chk("t3_stall_id", res_option_id, 5);
            chk("t3_stall_price", res_price, 1000);
            @(negedge clk);
        end
        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t3_drain_valid", res_valid, 1);
            chk("t3_drain_eng", res_engine, j);
            chk("t3_drain_id", res_option_id, 5 + j);
            chk("t3_drain_price", res_price, 1000 + j);
            @(negedge clk);
        end
        chk("t3_empty", res_valid, 0);

        // Dispatch concurrent with a completion; freed slot usable only afterwards
        do_reset();
        res_ready = 1'b1;
        dispatch_seq("t4", 1, 3, 0);
        in_valid = 1'b1; in_packet = mk_pkt(7);
        eng_done = 4'b0010; set_price(1, 222);
        @(negedge clk);
        in_valid = 1'b0; eng_done = '0;
        chk("t4_disp", eng_start, 4'b1000);
        chk("t4_not_ready", in_ready, 0);
        @(negedge clk);
        chk("t4_res_valid", res_valid, 1);
        chk("t4_res_eng", res_engine, 1);
        chk("t4_res_id", res_option_id, 2);
        chk("t4_res_price", res_price, 222);
        chk("t4_ready_again", in_ready, 1);
        chk("t4_busy3", busy_count, 3);
        in_valid = 1'b1; in_packet = mk_pkt(8);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_reuse", eng_start, 4'b0010);
        chk("t4_busy4", busy_count, 4);

        // Spurious completion on an idle slot
        do_reset();
        eng_done = 4'b1000;
        @(negedge clk);
        eng_done = '0;
        chk("t5_err", err_spurious, 1);
        chk("t5_no_res", res_valid, 0);
        chk("t5_busy", busy_count, 0);
        @(negedge clk);
        chk("t5_no_res2", res_valid, 0);
        chk("t5_err_sticky", err_spurious, 1);

        // Asynchronous reset mid-operation
        do_reset();
        dispatch_seq("t6", 1, 4, 0);
        eng_done = 4'b1000; set_price(3, 99);
        @(negedge clk);
        eng_done = '0;
        @(negedge clk);
        chk("t6_pre_valid", res_valid, 1);
        chk("t6_pre_busy", busy_count, 3);
        #2 rst = 1'b1;
        #1;
        chk("t6_res_valid", res_valid, 0);
        chk("t6_busy", busy_count, 0);
        chk("t6_eng_start", eng_start, 0);
        chk("t6_eng_packet", eng_packet, 0);
        chk("t6_res_id", res_option_id, 0);
        chk("t6_res_price", res_price, 0);
        chk("t6_res_eng", res_engine, 0);
        chk("t6_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        dispatch_seq("t6_after", 9, 1, 0);

        // Randomized traffic against a transaction-level reference
        do_reset();
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 0; run[k] = 0; pend[k] = 0; timer[k] = 0; done_cyc[k] = 0;
            exp_id[k] = '0; exp_price[k] = '0;
        end
        m_dptr = 0; m_rptr = 0; cyc = 0; disp_pending = 0; prev_valid = 0; prev_ready = 0;
        stuck = 0; held_id = '0; held_price = '0; held_eng = 0; exp_pkt = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            cyc++;
            // start pulse from the previous acceptance
            if (disp_pending) begin
                chk("r_start", eng_start, 4'b0001 << exp_grant);
                chk("r_pkt", eng_packet, exp_pkt);
                m_busy[exp_grant] = 1;
                run[exp_grant] = 1;
                timer[exp_grant] = $urandom_range(0, 12);
                exp_id[exp_grant] = exp_pkt[PKT_W-1 -: 32];
                disp_pending = 0;
            end else begin
                chk("r_nostart", eng_start, 0);
            end
            // output register behaviour
            if (prev_valid && !prev_ready) begin
                exp_v = 1;
                chk("r_hold_id", res_option_id, held_id);
                chk("r_hold_price", res_price, held_price);
                chk("r_hold_eng", res_engine, held_eng);
            end else begin
                exp_v = 0;
                e_exp = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    c = (m_rptr + i) % N;
                    if (pend[c] && done_cyc[c] <= cyc - 2) begin
                        exp_v = 1;
                        e_exp = c;
                    end
                end
                if (exp_v) begin
                    chk("r_eng", res_engine, e_exp);
                    chk("r_id", res_option_id, exp_id[e_exp]);
                    chk("r_price", res_price, exp_price[e_exp]);
                    held_id = exp_id[e_exp]; held_price = exp_price[e_exp]; held_eng = e_exp;
                    pend[e_exp] = 0;
                    m_busy[e_exp] = 0;
                    m_rptr = (e_exp + 1) % N;
                end
            end
            chk("r_valid", res_valid, exp_v);
            nbusy = 0;
            any_free = 0;
            for (int k = 0; k < N; k++) begin
                if (m_busy[k]) nbusy++;
                else any_free = 1;
            end
            chk("r_busy", busy_count, nbusy);
            chk("r_ready", in_ready, any_free);
            chk("r_err", err_spurious, 0);
            // engines
            eng_done = '0;
            for (int k = 0; k < N; k++) begin
                pr = $urandom;
                set_price(k, pr);
                if (run[k]) begin
                    if (timer[k] == 0) begin
                        eng_done[k] = 1'b1;
                        exp_price[k] = pr;
                        pend[k] = 1;
                        done_cyc[k] = cyc;
                        run[k] = 0;
                    end else begin
                        timer[k]--;
                    end
                end
            end
            // downstream
            prev_valid = exp_v;
            res_ready = ($urandom_range(0, 3) != 0);
            prev_ready = res_ready;
            // upstream: a refused packet stays presented unchanged
            if (!stuck) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_packet = mk_pkt($urandom);
            end
            acc = in_valid && any_free;
            if (acc) begin
                exp_grant = -1;
                for (int i = 0; i < N; i++) begin
                    c = (m_dptr + i) % N;
                    if (exp_grant < 0 && !m_busy[c]) exp_grant = c;
                end
                exp_pkt = in_packet;
                disp_pending = 1;
                m_dptr = (exp_grant + 1) % N;
            end
            stuck = in_valid && !acc;
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
